// File: rtl/mem_ptr_update_unit.sv
// ---------------------------------------------------------------------------
// mem_ptr_update_unit
//
// Holds the architectural X, Y, Z and stack pointers. For each accepted
// access it applies plain / post-increment / pre-decrement / load to the
// selected pointer. It presents one registered pointer set to the
// memory-stage address mux, together with the delayed pointer select.
//
// Optional feature: define PTR_STACK_LIMIT_CHECK_EN to enable the sticky
// stack-overflow flag. The flag sets when an accepted SP pre-decrement or
// SP load produces a value below STACK_LIMIT. When the macro is undefined,
// stack_ovf is tied low.
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   synchronous active-high reset
//   in_valid     in   execute stage presents an access
//   stall        in   memory stage stalled, hold all state
//   flush        in   squash the in-flight access (beats stall/in_valid)
//   sel_signals  in   pointer select: 00 SP, 01 X, 10 Y, 11 Z
//   ptr_op       in   00 plain, 01 post-inc, 10 pre-dec, 11 load
//   load_data    in   new pointer value for a load
//   x_ptr/y_ptr/z_ptr/stack_ptr  out  registered effective pointers
//   sel_out      out  sel_signals delayed one cycle
//   mem_valid    out  registered memory-access valid
//   stack_ovf    out  sticky stack-limit overflow flag
// ---------------------------------------------------------------------------
module mem_ptr_update_unit #(
  parameter int unsigned            ADDR_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0]  PTR_RESET   = 16'h0000,
  parameter logic [ADDR_WIDTH-1:0]  SP_RESET    = 16'hFFFF,
  parameter logic [ADDR_WIDTH-1:0]  STACK_LIMIT = 16'hFF00
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [1:0]            sel_signals,
  input  logic [1:0]            ptr_op,
  input  logic [ADDR_WIDTH-1:0] load_data,
  output logic [ADDR_WIDTH-1:0] x_ptr,
  output logic [ADDR_WIDTH-1:0] y_ptr,
  output logic [ADDR_WIDTH-1:0] z_ptr,
  output logic [ADDR_WIDTH-1:0] stack_ptr,
  output logic [1:0]            sel_out,
  output logic                  mem_valid,
  output logic                  stack_ovf
);

  localparam logic [1:0] SEL_SP = 2'b00;
  localparam logic [1:0] SEL_X  = 2'b01;
  localparam logic [1:0] SEL_Y  = 2'b10;
  localparam logic [1:0] SEL_Z  = 2'b11;

  localparam logic [1:0] OP_PLAIN   = 2'b00;
  localparam logic [1:0] OP_POSTINC = 2'b01;
  localparam logic [1:0] OP_PREDEC  = 2'b10;
  localparam logic [1:0] OP_LOAD    = 2'b11;

  localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  // Architectural pointers
  logic [ADDR_WIDTH-1:0] arch_x_q, arch_x_d;
  logic [ADDR_WIDTH-1:0] arch_y_q, arch_y_d;
  logic [ADDR_WIDTH-1:0] arch_z_q, arch_z_d;
  logic [ADDR_WIDTH-1:0] arch_sp_q, arch_sp_d;

  // Output registers toward the address mux
  logic [ADDR_WIDTH-1:0] x_ptr_q, x_ptr_d;
  logic [ADDR_WIDTH-1:0] y_ptr_q, y_ptr_d;
  logic [ADDR_WIDTH-1:0] z_ptr_q, z_ptr_d;
  logic [ADDR_WIDTH-1:0] sp_ptr_q, sp_ptr_d;
  logic [1:0]            sel_out_q, sel_out_d;
  logic                  mem_valid_q, mem_valid_d;

  logic [ADDR_WIDTH-1:0] arch_sel_s;
  logic [ADDR_WIDTH-1:0] eff_s;
  logic [ADDR_WIDTH-1:0] new_val_s;
  logic                  accept_s;

  assign accept_s = in_valid & ~stall & ~flush;

  // Select the addressed architectural pointer
  always_comb begin
    arch_sel_s = arch_sp_q;
    case (sel_signals)
      SEL_SP:  arch_sel_s = arch_sp_q;
      SEL_X:   arch_sel_s = arch_x_q;
      SEL_Y:   arch_sel_s = arch_y_q;
      SEL_Z:   arch_sel_s = arch_z_q;
      default: arch_sel_s = arch_sp_q;
    endcase
  end

  // Effective address and updated pointer value for the requested op
  always_comb begin
    eff_s     = arch_sel_s;
    new_val_s = arch_sel_s;
    case (ptr_op)
      OP_PLAIN: begin
        eff_s     = arch_sel_s;
        new_val_s = arch_sel_s;
      end
      OP_POSTINC: begin
        eff_s     = arch_sel_s;
        new_val_s = arch_sel_s + ONE;
      end
      OP_PREDEC: begin
        eff_s     = arch_sel_s - ONE;
        new_val_s = arch_sel_s - ONE;
      end
      OP_LOAD: begin
        eff_s     = load_data;
        new_val_s = load_data;
      end
      default: begin
        eff_s     = arch_sel_s;
        new_val_s = arch_sel_s;
      end
    endcase
  end

  // Next-state for architectural and output registers
  always_comb begin
    arch_x_d    = arch_x_q;
    arch_y_d    = arch_y_q;
    arch_z_d    = arch_z_q;
    arch_sp_d   = arch_sp_q;
    x_ptr_d     = x_ptr_q;
    y_ptr_d     = y_ptr_q;
    z_ptr_d     = z_ptr_q;
    sp_ptr_d    = sp_ptr_q;
    sel_out_d   = sel_out_q;
    mem_valid_d = mem_valid_q;
    if (flush) begin
      // Squash: drop the access, pointers and select hold
      mem_valid_d = 1'b0;
    end else if (stall) begin
      // Full hold so the memory stage re-sees the same access
      mem_valid_d = mem_valid_q;
    end else if (in_valid) begin
      // Unselected outputs show their architectural value
      x_ptr_d  = (sel_signals == SEL_X)  ? eff_s : arch_x_q;
      y_ptr_d  = (sel_signals == SEL_Y)  ? eff_s : arch_y_q;
      z_ptr_d  = (sel_signals == SEL_Z)  ? eff_s : arch_z_q;
      sp_ptr_d = (sel_signals == SEL_SP) ? eff_s : arch_sp_q;
      arch_x_d  = (sel_signals == SEL_X)  ? new_val_s : arch_x_q;
      arch_y_d  = (sel_signals == SEL_Y)  ? new_val_s : arch_y_q;
      arch_z_d  = (sel_signals == SEL_Z)  ? new_val_s : arch_z_q;
      arch_sp_d = (sel_signals == SEL_SP) ? new_val_s : arch_sp_q;
      sel_out_d = sel_signals;
      // A load only writes the pointer; there is no memory access
      mem_valid_d = (ptr_op != OP_LOAD);
    end else begin
      mem_valid_d = 1'b0;
      x_ptr_d     = arch_x_q;
      y_ptr_d     = arch_y_q;
      z_ptr_d     = arch_z_q;
      sp_ptr_d    = arch_sp_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      arch_x_q    <= PTR_RESET;
      arch_y_q    <= PTR_RESET;
      arch_z_q    <= PTR_RESET;
      arch_sp_q   <= SP_RESET;
      x_ptr_q     <= PTR_RESET;
      y_ptr_q     <= PTR_RESET;
      z_ptr_q     <= PTR_RESET;
      sp_ptr_q    <= SP_RESET;
      sel_out_q   <= 2'b00;
      mem_valid_q <= 1'b0;
    end else begin
      arch_x_q    <= arch_x_d;
      arch_y_q    <= arch_y_d;
      arch_z_q    <= arch_z_d;
      arch_sp_q   <= arch_sp_d;
      x_ptr_q     <= x_ptr_d;
      y_ptr_q     <= y_ptr_d;
      z_ptr_q     <= z_ptr_d;
      sp_ptr_q    <= sp_ptr_d;
      sel_out_q   <= sel_out_d;
      mem_valid_q <= mem_valid_d;
    end
  end

`ifdef PTR_STACK_LIMIT_CHECK_EN
  logic stack_ovf_q, stack_ovf_d;
  logic sp_limit_hit_s;

  // Only SP writes that move it downward or replace it can cross the limit
  assign sp_limit_hit_s = accept_s && (sel_signals == SEL_SP) &&
                          ((ptr_op == OP_PREDEC) || (ptr_op == OP_LOAD)) &&
                          (new_val_s < STACK_LIMIT);

  // Sticky overflow next-state
  always_comb begin
    stack_ovf_d = stack_ovf_q | sp_limit_hit_s;
  end

  // Overflow flag register, cleared only by reset
  always_ff @(posedge clock) begin
    if (reset) begin
      stack_ovf_q <= 1'b0;
    end else begin
      stack_ovf_q <= stack_ovf_d;
    end
  end

  assign stack_ovf = stack_ovf_q;
`else
  logic unused_limit_s;
  assign unused_limit_s = (^STACK_LIMIT) ^ accept_s;
  assign stack_ovf      = 1'b0;
`endif

  assign x_ptr     = x_ptr_q;
  assign y_ptr     = y_ptr_q;
  assign z_ptr     = z_ptr_q;
  assign stack_ptr = sp_ptr_q;
  assign sel_out   = sel_out_q;
  assign mem_valid = mem_valid_q;

endmodule

// File: tb/tb_mem_ptr_update_unit.sv
// Directed testbench for mem_ptr_update_unit.
module tb_mem_ptr_update_unit;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        stall;
  logic        flush;
  logic [1:0]  sel_signals;
  logic [1:0]  ptr_op;
  logic [15:0] load_data;
  logic [15:0] x_ptr, y_ptr, z_ptr, stack_ptr;
  logic [1:0]  sel_out;
  logic        mem_valid;
  logic        stack_ovf;

  int vectors = 0;
  int errors  = 0;

`ifdef PTR_STACK_LIMIT_CHECK_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  mem_ptr_update_unit dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .stall      (stall),
    .flush      (flush),
    .sel_signals(sel_signals),
    .ptr_op     (ptr_op),
    .load_data  (load_data),
    .x_ptr      (x_ptr),
    .y_ptr      (y_ptr),
    .z_ptr      (z_ptr),
    .stack_ptr  (stack_ptr),
    .sel_out    (sel_out),
    .mem_valid  (mem_valid),
    .stack_ovf  (stack_ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic drv(input logic v, input logic s, input logic f,
                     input logic [1:0] sel, input logic [1:0] op,
                     input logic [15:0] d);
    in_valid    = v;
    stall       = s;
    flush       = f;
    sel_signals = sel;
    ptr_op      = op;
    load_data   = d;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'h0000);
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drv(1'b1, 1'b0, 1'b0, 2'b01, 2'b11, 16'hAAAA);
    tick();
    tick();
    reset = 1'b0;
    vectors++;
    if (x_ptr !== 16'h0000 || y_ptr !== 16'h0000 || z_ptr !== 16'h0000) begin
      $display("FAIL reset_xyz: got %h %h %h want 0000", x_ptr, y_ptr, z_ptr); errors++;
    end
    vectors++;
    if (stack_ptr !== 16'hFFFF) begin
      $display("FAIL reset_sp: got %h want FFFF", stack_ptr); errors++;
    end
    vectors++;
    if (mem_valid !== 1'b0 || sel_out !== 2'b00 || stack_ovf !== 1'b0) begin
      $display("FAIL reset_ctl: mv=%b sel=%b ovf=%b want 0 00 0", mem_valid, sel_out, stack_ovf); errors++;
    end
  endtask

  task automatic test_load_plain();
    drv(1'b1, 1'b0, 1'b0, 2'b01, 2'b11, 16'h1234);
    tick();
    vectors++;
    if (mem_valid !== 1'b0 || x_ptr !== 16'h1234 || sel_out !== 2'b01) begin
      $display("FAIL load_x: mv=%b x=%h sel=%b want 0 1234 01", mem_valid, x_ptr, sel_out); errors++;
    end
    drv(1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 16'h0000);
    tick();
    vectors++;
    if (mem_valid !== 1'b1 || x_ptr !== 16'h1234 || sel_out !== 2'b01) begin
      $display("FAIL plain_x: mv=%b x=%h sel=%b want 1 1234 01", mem_valid, x_ptr, sel_out); errors++;
    end
  endtask

  task automatic test_push_pop();
    drv(1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 16'h0000);
    tick();
    vectors++;
    if (stack_ptr !== 16'hFFFE || mem_valid !== 1'b1 || sel_out !== 2'b00) begin
      $display("FAIL push1: sp=%h mv=%b sel=%b want FFFE 1 00", stack_ptr, mem_valid, sel_out); errors++;
    end
    tick();
    vectors++;
    if (stack_ptr !== 16'hFFFD) begin
      $display("FAIL push2: sp=%h want FFFD", stack_ptr); errors++;
    end
    drv(1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 16'h0000);
    tick();
    vectors++;
    if (stack_ptr !== 16'hFFFD || x_ptr !== 16'h1234) begin
      $display("FAIL pop: sp=%h x=%h want FFFD 1234", stack_ptr, x_ptr); errors++;
    end
    idle();
    vectors++;
    if (stack_ptr !== 16'hFFFE || mem_valid !== 1'b0) begin
      $display("FAIL pop_arch: sp=%h mv=%b want FFFE 0", stack_ptr, mem_valid); errors++;
    end
  endtask

  task automatic test_back_to_back();
    drv(1'b1, 1'b0, 1'b0, 2'b01, 2'b11, 16'h0010);
    tick();
    drv(1'b1, 1'b0, 1'b0, 2'b01, 2'b01, 16'h0000);
    tick();
    vectors++;
    if (x_ptr !== 16'h0010 || mem_valid !== 1'b1) begin
      $display("FAIL b2b_first: x=%h mv=%b want 0010 1", x_ptr, mem_valid); errors++;
    end
    tick();
    vectors++;
    if (x_ptr !== 16'h0011) begin
      $display("FAIL b2b_second: x=%h want 0011", x_ptr); errors++;
    end
    idle();
    vectors++;
    if (x_ptr !== 16'h0012) begin
      $display("FAIL b2b_arch: x=%h want 0012", x_ptr); errors++;
    end
  endtask

  task automatic test_wrap();
    drv(1'b1, 1'b0, 1'b0, 2'b11, 2'b11, 16'hFFFF);
    tick();
    drv(1'b1, 1'b0, 1'b0, 2'b11, 2'b01, 16'h0000);
    tick();
    vectors++;
    if (z_ptr !== 16'hFFFF || sel_out !== 2'b11) begin
      $display("FAIL wrap_z: z=%h sel=%b want FFFF 11", z_ptr, sel_out); errors++;
    end
    idle();
    vectors++;
    if (z_ptr !== 16'h0000) begin
      $display("FAIL wrap_z_arch: z=%h want 0000", z_ptr); errors++;
    end
    drv(1'b1, 1'b0, 1'b0, 2'b10, 2'b10, 16'h0000);
    tick();
    vectors++;
    if (y_ptr !== 16'hFFFF || mem_valid !== 1'b1) begin
      $display("FAIL wrap_y: y=%h mv=%b want FFFF 1", y_ptr, mem_valid); errors++;
    end
    idle();
  endtask

  task automatic test_stall_flush();
    drv(1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 16'h0000);
    tick();
    drv(1'b1, 1'b1, 1'b0, 2'b10, 2'b01, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (y_ptr !== 16'hFFFF || x_ptr !== 16'h0012 || mem_valid !== 1'b1 || sel_out !== 2'b01) begin
        $display("FAIL stall_hold%0d: y=%h x=%h mv=%b sel=%b want FFFF 0012 1 01",
                 i, y_ptr, x_ptr, mem_valid, sel_out); errors++;
      end
    end
    stall = 1'b0;
    tick();
    vectors++;
    if (y_ptr !== 16'hFFFF || sel_out !== 2'b10 || mem_valid !== 1'b1) begin
      $display("FAIL stall_release: y=%h sel=%b mv=%b want FFFF 10 1", y_ptr, sel_out, mem_valid); errors++;
    end
    idle();
    vectors++;
    if (y_ptr !== 16'h0000) begin
      $display("FAIL stall_arch: y=%h want 0000", y_ptr); errors++;
    end
    drv(1'b1, 1'b1, 1'b1, 2'b01, 2'b01, 16'h0000);
    tick();
    vectors++;
    if (mem_valid !== 1'b0 || x_ptr !== 16'h0012 || sel_out !== 2'b10) begin
      $display("FAIL flush: mv=%b x=%h sel=%b want 0 0012 10", mem_valid, x_ptr, sel_out); errors++;
    end
    idle();
    vectors++;
    if (x_ptr !== 16'h0012) begin
      $display("FAIL flush_arch: x=%h want 0012", x_ptr); errors++;
    end
  endtask

  task automatic test_stack_ovf();
    drv(1'b1, 1'b0, 1'b0, 2'b00, 2'b11, 16'hFF00);
    tick();
    vectors++;
    if (stack_ptr !== 16'hFF00 || stack_ovf !== 1'b0) begin
      $display("FAIL ovf_at_limit: sp=%h ovf=%b want FF00 0", stack_ptr, stack_ovf); errors++;
    end
    drv(1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 16'h0000);
    tick();
    vectors++;
    if (stack_ptr !== 16'hFEFF || stack_ovf !== OVF_EXP) begin
      $display("FAIL ovf_set: sp=%h ovf=%b want FEFF %b", stack_ptr, stack_ovf, OVF_EXP); errors++;
    end
    drv(1'b1, 1'b0, 1'b0, 2'b00, 2'b11, 16'hFFF0);
    tick();
    idle();
    vectors++;
    if (stack_ptr !== 16'hFFF0 || stack_ovf !== OVF_EXP) begin
      $display("FAIL ovf_sticky: sp=%h ovf=%b want FFF0 %b", stack_ptr, stack_ovf, OVF_EXP); errors++;
    end
  endtask

  task automatic test_reset_mid_op();
    drv(1'b1, 1'b0, 1'b0, 2'b11, 2'b11, 16'h5555);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (z_ptr !== 16'h0000 || stack_ptr !== 16'hFFFF || x_ptr !== 16'h0000 ||
        mem_valid !== 1'b0 || sel_out !== 2'b00 || stack_ovf !== 1'b0) begin
      $display("FAIL reset_mid: z=%h sp=%h x=%h mv=%b sel=%b ovf=%b want 0000 FFFF 0000 0 00 0",
               z_ptr, stack_ptr, x_ptr, mem_valid, sel_out, stack_ovf); errors++;
    end
    idle();
    vectors++;
    if (z_ptr !== 16'h0000 || x_ptr !== 16'h0000) begin
      $display("FAIL reset_mid_arch: z=%h x=%h want 0000 0000", z_ptr, x_ptr); errors++;
    end
  endtask

  initial begin
    reset = 1'b1;
    drv(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'h0000);
    test_reset();
    test_load_plain();
    test_push_pop();
    test_back_to_back();
    test_wrap();
    test_stall_flush();
    test_stack_ovf();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
